// File: rtl/hd_loader_pkg.sv
// Shared state encoding and default widths for the HD-to-memory block loader.
package hd_loader_pkg;

  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefHdAddrWidth  = 12;
  localparam int unsigned DefMemAddrWidth = 10;
  localparam int unsigned DefLenWidth     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/hd_loader.sv
// Copies a block of words from a synchronous-read HD array into a destination memory.
// Optional HD_LOADER_CHECKSUM_EN adds an XOR checksum of the words written.
module hd_loader
  import hd_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned HD_ADDR_WIDTH  = DefHdAddrWidth,
  parameter int unsigned MEM_ADDR_WIDTH = DefMemAddrWidth,
  parameter int unsigned LEN_WIDTH      = DefLenWidth
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [HD_ADDR_WIDTH-1:0]  src_base,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]      length,
  input  logic [DATA_WIDTH-1:0]     hd_q,
  output logic [HD_ADDR_WIDTH-1:0]  hd_addr,
  output logic                      hd_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      mem_we,
  output logic                      busy,
  output logic                      done,
`ifdef HD_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]     checksum,
`endif
  output logic [LEN_WIDTH-1:0]      words_copied
);

  state_e                    state_q, state_d;
  logic [HD_ADDR_WIDTH-1:0]  src_q, src_d;
  logic [MEM_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      wc_q, wc_d;
  logic                      accept;

  assign hd_we        = 1'b0;
  assign words_copied = wc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    wc_d     = wc_q;
    accept   = 1'b0;
    hd_addr  = '0;
    mem_addr = '0;
    mem_data = '0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = length;
          wc_d    = '0;
          state_d = (length != '0) ? StFetch : StDone;
        end
      end
      StFetch: begin
        hd_addr = src_q;
        state_d = abort ? StDone : StStream;
      end
      StStream: begin
        // The word counter doubles as the stream index i.
        if (abort) begin
          state_d = StDone;
        end else begin
          mem_we   = 1'b1;
          mem_addr = dst_q + MEM_ADDR_WIDTH'(wc_q);
          mem_data = hd_q;
          hd_addr  = src_q + HD_ADDR_WIDTH'(wc_q) + HD_ADDR_WIDTH'(1);
          wc_d     = wc_q + LEN_WIDTH'(1);
          if (wc_q == len_q - LEN_WIDTH'(1)) state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef HD_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (mem_we) begin
      csum_q <= csum_q ^ mem_data;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_hd_loader.sv
// Self-checking bench for hd_loader: directed corner cases plus randomized copies
// compared against a word-list reference model.
module tb_hd_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] src_base = '0;
  logic [9:0]  dst_base = '0;
  logic [7:0]  length = '0;
  logic [31:0] hd_q = '0;
  logic [11:0] hd_addr;
  logic        hd_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [7:0]  words_copied;
`ifdef HD_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] hd_mem [4096];
  int last_wc = 0;

  hd_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .length      (length),
    .hd_q        (hd_q),
    .hd_addr     (hd_addr),
    .hd_we       (hd_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
`ifdef HD_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .words_copied(words_copied)
  );

  always #5 clk = ~clk;

  // Synchronous-read HD array: data appears one cycle after the address.
  always @(posedge clk) hd_q <= hd_mem[hd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a copy, optionally abort in cycle abort_k (1 = FETCH), optionally poke start mid-run.
  task automatic run_copy(input int src, input int dst, input int len, input int abort_k,
                          input bit glitch);
    logic [41:0] got[$];
    logic [31:0] exp_sum = '0;
    int n_exp, done_exp, done_cyc = 0, done_cnt = 0, busy_cnt = 0;
    n_exp    = (abort_k == 0) ? len : ((abort_k < 2) ? 0 : abort_k - 2);
    done_exp = (abort_k != 0) ? abort_k + 1 : ((len == 0) ? 1 : len + 2);
    @(negedge clk);
    src_base = 12'(src);
    dst_base = 10'(dst);
    length   = 8'(len);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      abort = (k == abort_k);
      start = glitch && (k == 3);
      if (start) begin
        src_base = 12'($urandom);
        dst_base = 10'($urandom);
        length   = 8'($urandom_range(1, 9));
      end
      #1;
      if (busy) busy_cnt++;
      if (mem_we) got.push_back({mem_addr, mem_data});
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (k <= len && (abort_k == 0 || k < abort_k))
        chk("hd_addr", 64'(hd_addr), 64'((src + k - 1) % 4096));
      if (done_cyc != 0 && k == done_cyc + 1) break;
    end
    abort = 1'b0;
    start = 1'b0;
    chk("write_count", 64'(got.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < got.size(); i++) begin
      chk("write_addr", 64'(got[i][41:32]), 64'((dst + i) % 1024));
      chk("write_data", 64'(got[i][31:0]), 64'(hd_mem[(src + i) % 4096]));
      exp_sum ^= hd_mem[(src + i) % 4096];
    end
    chk("done_cycle", 64'(done_cyc), 64'(done_exp));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'(done_exp));
    chk("busy_after", 64'(busy), 64'd0);
    chk("words_copied", 64'(words_copied), 64'(n_exp));
`ifdef HD_LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
    last_wc = n_exp;
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 4096; i++) hd_mem[i] = $urandom;
    for (int i = 0; i < 5; i++) hd_mem[128 + i] = 32'hA0A0_0000 + 32'(i);

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_hd_addr", 64'(hd_addr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_wc", 64'(words_copied), 64'd0);
    chk("hd_we", 64'(hd_we), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_copy(128, 0, 5, 0, 1'b0);
    run_copy(7, 9, 0, 0, 1'b0);
    run_copy(4094, 1022, 4, 0, 1'b0);
    run_copy(300, 50, 10, 4, 1'b0);
    run_copy(600, 700, 3, 1, 1'b0);

    // Abort in IDLE is ignored and words_copied holds
    abort = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_wc_hold", 64'(words_copied), 64'(last_wc));
    abort = 1'b0;

    // Asynchronous reset mid-STREAM
    @(negedge clk);
    src_base = 12'd1000;
    dst_base = 10'd200;
    length   = 8'd10;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mem_we", 64'(mem_we), 64'd0);
    chk("arst_wc", 64'(words_copied), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (done || mem_we) dn++;
    end
    chk("arst_no_done", 64'(dn), 64'd0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 24);
      run_copy($urandom_range(0, 4095), $urandom_range(0, 1023), len,
               (r % 3 == 2) ? $urandom_range(1, len + 1) : 0, len >= 3);
    end

`ifdef HD_LOADER_CHECKSUM_EN
    hd_mem[2000] = 32'd1;
    hd_mem[2001] = 32'd2;
    hd_mem[2002] = 32'd4;
    run_copy(2000, 10, 3, 0, 1'b0);
    chk("checksum_7", 64'(checksum), 64'd7);
    run_copy(2001, 20, 1, 0, 1'b0);
    chk("checksum_cleared", 64'(checksum), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
